reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, number of station entries (2..8).
REQ-002 SHALL have parameter TAG_BASE, default 1, tag of entry 0; entry i owns tag TAG_BASE+i, never NO_VAL.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port issue_valid_i  input  1  issue request this cycle.
REQ-006 SHALL have port issue_op_i  input  op_t  operation code.
REQ-007 SHALL have ports issue_qj_i / issue_qk_i  input  tag width  producer tags; NO_VAL means the operand value is present.
REQ-008 SHALL have ports issue_vj_i / issue_vk_i  input  val width  operand values, meaningful only when the matching tag is NO_VAL.
REQ-009 SHALL have port issue_ready_o  output  1  at least one FREE entry.
REQ-010 SHALL have port issue_tag_o  output  tag width  tag of the entry the next issue allocates.
REQ-011 SHALL have port cdb_i  input  cdb_t  broadcast bus (tag, val).
REQ-012 SHALL have port fu_ready_i  input  1  functional unit accepts a dispatch this cycle.
REQ-013 SHALL have ports dispatch_valid_o 1, dispatch_op_o op_t, dispatch_a_o / dispatch_b_o val width, dispatch_tag_o tag width  outputs to the functional unit.

Function
REQ-014 SHALL keep a per-entry state of FREE, WAITING, READY or EXECUTING, plus op, Qj, Qk, Vj and Vk.
REQ-015 SHALL allocate the lowest-index FREE entry when issue_valid_i && issue_ready_o; the entry is written at the clock edge.
REQ-016 SHALL drive issue_ready_o and issue_tag_o combinationally from registered state only; with no FREE entry, issue_tag_o = NO_VAL and issue_valid_i is ignored.
REQ-017 SHALL capture cdb_i.val into Vj and clear Qj to NO_VAL at the edge where cdb_i.tag == Qj != NO_VAL; Qk is handled identically and independently.
REQ-018 SHALL capture cdb_i.val at the issuing edge when issue_qj_i or issue_qk_i equals cdb_i.tag != NO_VAL (same-cycle bypass).
REQ-019 SHALL set an entry to READY after any edge at which both of its tags are NO_VAL, and to WAITING otherwise.
REQ-020 SHALL assert dispatch_valid_o when any entry is READY, driving the selected entry's op, Vj, Vk and own tag.
REQ-021 SHALL move the selected entry to EXECUTING at the edge where dispatch_valid_o && fu_ready_i; at most one dispatch occurs per cycle.
REQ-022 SHALL return an EXECUTING entry to FREE at the edge where cdb_i.tag equals its own tag; the freed entry is allocatable from the next cycle.
REQ-023 SHALL ignore a cdb_i.tag matching the own tag of an entry that is not EXECUTING.
REQ-024 SHALL never match NO_VAL on cdb_i against any tag.
REQ-025 SHALL make a newly issued operand-complete entry eligible for dispatch no earlier than the cycle after issue (minimum issue-to-dispatch latency 1).

Reset
REQ-026 SHALL, while RST_i is high, set all entries to FREE and ignore issue_valid_i, cdb_i and fu_ready_i.
REQ-027 SHALL, in the cycle after reset, present dispatch_valid_o = 0, issue_ready_o = 1 and issue_tag_o = TAG_BASE.
REQ-028 SHALL, on reset mid-operation, discard all in-flight entries, including EXECUTING ones.

Configuration
REQ-029 SHALL, with RS_OLDEST_FIRST_EN defined, select for dispatch the READY entry issued earliest, using per-entry age counters of width clog2(NUM_ENTRIES).
REQ-030 SHALL, without RS_OLDEST_FIRST_EN, select the lowest-index READY entry and include no age logic.

Structure
REQ-031 SHALL take cdb_t, NO_VAL and op_t from the shared package data_types; the entry-state enum SHALL also live in data_types.
REQ-032 SHALL use priority_encoder (N=NUM_ENTRIES) for free-entry allocation and, in the lowest-index build, for dispatch selection.

Verification
REQ-033 SHALL cover: reset, then issue op=ADD, qj=qk=NO_VAL, vj=3, vk=4 -> next cycle dispatch_valid_o=1, a=3, b=4, tag=1.
REQ-034 SHALL cover: issue with qj=7; later cdb_i={7,0x55} -> Vj=0x55, and dispatch follows one cycle after the capture edge.
REQ-035 SHALL cover: issue with qk=5 in the same cycle as cdb_i={5,9} -> dispatch next cycle with b=9.
REQ-036 SHALL cover: fill all 4 entries -> issue_ready_o=0 and issue_tag_o=NO_VAL; cdb_i.tag=2 while entry 1 is EXECUTING -> issue_ready_o=1 and issue_tag_o=2 next cycle.
REQ-037 SHALL cover: two READY entries with fu_ready_i=0 for 3 cycles -> no state change; then fu_ready_i=1 -> one dispatch per cycle, ordered by index (or by age with RS_OLDEST_FIRST_EN).
REQ-038 SHALL cover: RST_i asserted while entries are EXECUTING -> next cycle all entries FREE and dispatch_valid_o=0.

Source files
------------

// File: rtl/data_types.sv
// rtl/data_types.sv - shared tag/value/op/CDB types and station entry states
package data_types;

    localparam int TAG_W = 4;
    localparam int VAL_W = 32;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [VAL_W-1:0] val_t;

    // Tag value meaning "operand present"; no entry ever owns it.
    localparam tag_t NO_VAL = '0;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR
    } op_t;

    typedef struct packed {
        tag_t tag;
        val_t val;
    } cdb_t;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_WAITING,
        ST_READY,
        ST_EXECUTING
    } rs_state_t;

    function automatic logic tag_hit(tag_t a, tag_t b);
        return (a != NO_VAL) && (a == b);
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - lowest-index set bit of a request vector
module priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int W = $clog2(N);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - tag-matching reservation station; RS_OLDEST_FIRST_EN selects oldest-ready dispatch
module reservation_station
    import data_types::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE    = 1
) (
    input  logic clk_i,
    input  logic RST_i,
    input  logic issue_valid_i,
    input  op_t  issue_op_i,
    input  tag_t issue_qj_i,
    input  tag_t issue_qk_i,
    input  val_t issue_vj_i,
    input  val_t issue_vk_i,
    output logic issue_ready_o,
    output tag_t issue_tag_o,
    input  cdb_t cdb_i,
    input  logic fu_ready_i,
    output logic dispatch_valid_o,
    output op_t  dispatch_op_o,
    output val_t dispatch_a_o,
    output val_t dispatch_b_o,
    output tag_t dispatch_tag_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    rs_state_t state_q [NUM_ENTRIES];
    rs_state_t state_d [NUM_ENTRIES];
    op_t       op_q    [NUM_ENTRIES];
    op_t       op_d    [NUM_ENTRIES];
    tag_t      qj_q    [NUM_ENTRIES];
    tag_t      qj_d    [NUM_ENTRIES];
    tag_t      qk_q    [NUM_ENTRIES];
    tag_t      qk_d    [NUM_ENTRIES];
    val_t      vj_q    [NUM_ENTRIES];
    val_t      vj_d    [NUM_ENTRIES];
    val_t      vk_q    [NUM_ENTRIES];
    val_t      vk_d    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] ready_vec;
    logic [IDX_W-1:0]       alloc_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   free_any;
    logic                   any_ready;
    logic                   issue_fire;
    logic                   dispatch_fire;

    function automatic tag_t own_tag(int i);
        return tag_t'(TAG_BASE + i);
    endfunction

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i]  = (state_q[i] == ST_FREE);
            ready_vec[i] = (state_q[i] == ST_READY);
        end
    end

    priority_encoder #(.N(NUM_ENTRIES)) u_alloc_pe (
        .req   (free_vec),
        .idx   (alloc_idx),
        .valid (free_any)
    );

    assign issue_ready_o = free_any;
    assign issue_tag_o   = free_any ? (tag_t'(TAG_BASE) + tag_t'(alloc_idx)) : NO_VAL;
    assign issue_fire    = issue_valid_i && free_any;

`ifdef RS_OLDEST_FIRST_EN
    // age = number of younger occupied entries, so the oldest has the largest age
    logic [IDX_W-1:0] age_q [NUM_ENTRIES];
    logic [IDX_W-1:0] best_age;
    logic [IDX_W-1:0] retire_age;
    logic             retire_any;

    always_comb begin
        sel_idx   = '0;
        best_age  = '0;
        any_ready = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready_vec[i] && (!any_ready || age_q[i] > best_age)) begin
                sel_idx   = IDX_W'(i);
                best_age  = age_q[i];
                any_ready = 1'b1;
            end
        end
    end

    always_comb begin
        retire_any = 1'b0;
        retire_age = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_q[i] == ST_EXECUTING && tag_hit(cdb_i.tag, own_tag(i))) begin
                retire_any = 1'b1;
                retire_age = age_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (RST_i) begin
                age_q[i] <= '0;
            end else if (issue_fire && alloc_idx == IDX_W'(i)) begin
                age_q[i] <= '0;
            end else if (state_q[i] != ST_FREE) begin
                age_q[i] <= age_q[i] + IDX_W'(issue_fire)
                          - IDX_W'(retire_any && (age_q[i] > retire_age));
            end
        end
    end
`else
    priority_encoder #(.N(NUM_ENTRIES)) u_disp_pe (
        .req   (ready_vec),
        .idx   (sel_idx),
        .valid (any_ready)
    );
`endif

    assign dispatch_valid_o = any_ready;
    assign dispatch_op_o    = op_q[sel_idx];
    assign dispatch_a_o     = vj_q[sel_idx];
    assign dispatch_b_o     = vk_q[sel_idx];
    assign dispatch_tag_o   = tag_t'(TAG_BASE) + tag_t'(sel_idx);
    assign dispatch_fire    = any_ready && fu_ready_i;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (issue_fire && alloc_idx == IDX_W'(i)) begin
                        op_d[i] = issue_op_i;
                        // same-cycle bypass from the CDB into the newly issued entry
                        qj_d[i] = tag_hit(issue_qj_i, cdb_i.tag) ? NO_VAL : issue_qj_i;
                        vj_d[i] = tag_hit(issue_qj_i, cdb_i.tag) ? cdb_i.val : issue_vj_i;
                        qk_d[i] = tag_hit(issue_qk_i, cdb_i.tag) ? NO_VAL : issue_qk_i;
                        vk_d[i] = tag_hit(issue_qk_i, cdb_i.tag) ? cdb_i.val : issue_vk_i;
                        state_d[i] = (qj_d[i] == NO_VAL && qk_d[i] == NO_VAL) ? ST_READY : ST_WAITING;
                    end
                end
                ST_WAITING: begin
                    if (tag_hit(qj_q[i], cdb_i.tag)) begin
                        qj_d[i] = NO_VAL;
                        vj_d[i] = cdb_i.val;
                    end
                    if (tag_hit(qk_q[i], cdb_i.tag)) begin
                        qk_d[i] = NO_VAL;
                        vk_d[i] = cdb_i.val;
                    end
                    state_d[i] = (qj_d[i] == NO_VAL && qk_d[i] == NO_VAL) ? ST_READY : ST_WAITING;
                end
                ST_READY: begin
                    if (dispatch_fire && sel_idx == IDX_W'(i)) begin
                        state_d[i] = ST_EXECUTING;
                    end
                end
                ST_EXECUTING: begin
                    if (tag_hit(cdb_i.tag, own_tag(i))) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: state_d[i] = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (RST_i) begin
                state_q[i] <= ST_FREE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Payload needs no reset: it is only observed once its entry leaves FREE.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!RST_i) begin
                op_q[i] <= op_d[i];
                qj_q[i] <= qj_d[i];
                qk_q[i] <= qk_d[i];
                vj_q[i] <= vj_d[i];
                vk_q[i] <= vk_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;
    import data_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic issue_valid = 1'b0;
    op_t  issue_op = OP_ADD;
    tag_t issue_qj = '0;
    tag_t issue_qk = '0;
    val_t issue_vj = '0;
    val_t issue_vk = '0;
    logic issue_ready;
    tag_t issue_tag;
    cdb_t cdb = '0;
    logic fu_ready = 1'b0;
    logic dispatch_valid;
    op_t  dispatch_op;
    val_t dispatch_a;
    val_t dispatch_b;
    tag_t dispatch_tag;

    typedef struct {
        op_t  op;
        val_t a;
        val_t b;
        tag_t tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reservation_station #(.NUM_ENTRIES(4), .TAG_BASE(1)) dut (
        .clk_i            (clk),
        .RST_i            (rst),
        .issue_valid_i    (issue_valid),
        .issue_op_i       (issue_op),
        .issue_qj_i       (issue_qj),
        .issue_qk_i       (issue_qk),
        .issue_vj_i       (issue_vj),
        .issue_vk_i       (issue_vk),
        .issue_ready_o    (issue_ready),
        .issue_tag_o      (issue_tag),
        .cdb_i            (cdb),
        .fu_ready_i       (fu_ready),
        .dispatch_valid_o (dispatch_valid),
        .dispatch_op_o    (dispatch_op),
        .dispatch_a_o     (dispatch_a),
        .dispatch_b_o     (dispatch_b),
        .dispatch_tag_o   (dispatch_tag)
    );

    // Every accepted dispatch must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && dispatch_valid && fu_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_dispatch got tag=%0d required=none", dispatch_tag);
            end else begin
                mon_e = sb.pop_front();
                if (dispatch_op !== mon_e.op || dispatch_a !== mon_e.a ||
                    dispatch_b !== mon_e.b || dispatch_tag !== mon_e.tag) begin
                    failures++;
                    $display("FAIL sb_dispatch got op=%0d a=%0h b=%0h tag=%0d required op=%0d a=%0h b=%0h tag=%0d",
                             dispatch_op, dispatch_a, dispatch_b, dispatch_tag,
                             mon_e.op, mon_e.a, mon_e.b, mon_e.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        cdb         = '{tag: NO_VAL, val: '0};
        fu_ready    = 1'b0;
    endtask

    task automatic drive_issue(op_t op, tag_t qj, tag_t qk, val_t vj, val_t vk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_qj    = qj;
        issue_qk    = qk;
        issue_vj    = vj;
        issue_vk    = vk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        issue_valid = 1'b1;
        fu_ready    = 1'b1;
        cdb         = '{tag: 4'd1, val: 32'h1};
        do_reset();
        checks++;
        if (dispatch_valid !== 1'b0 || issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            failures++;
            $display("FAIL reset_state got dv=%0b ir=%0b it=%0d required dv=0 ir=1 it=1",
                     dispatch_valid, issue_ready, issue_tag);
        end
    endtask

    task automatic test_ready_issue();
        do_reset();
        drive_issue(OP_ADD, NO_VAL, NO_VAL, 32'd3, 32'd4);
        checks++;
        if (issue_tag !== 4'd1 || dispatch_valid !== 1'b0) begin
            failures++;
            $display("FAIL ready_pre got it=%0d dv=%0b required it=1 dv=0", issue_tag, dispatch_valid);
        end
        sb.push_back('{op: OP_ADD, a: 32'd3, b: 32'd4, tag: 4'd1});
        tick();
        issue_valid = 1'b0;
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_tag !== 4'd1 || dispatch_a !== 32'd3 || dispatch_b !== 32'd4) begin
            failures++;
            $display("FAIL ready_latency got dv=%0b tag=%0d a=%0h b=%0h required dv=1 tag=1 a=3 b=4",
                     dispatch_valid, dispatch_tag, dispatch_a, dispatch_b);
        end
        cdb = '{tag: NO_VAL, val: 32'h77};
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        checks++;
        if (dispatch_a !== 32'd3 || dispatch_b !== 32'd4) begin
            failures++;
            $display("FAIL no_val_cdb got a=%0h b=%0h required a=3 b=4", dispatch_a, dispatch_b);
        end
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        checks++;
        if (dispatch_valid !== 1'b0 || issue_tag !== 4'd2) begin
            failures++;
            $display("FAIL executing got dv=%0b it=%0d required dv=0 it=2", dispatch_valid, issue_tag);
        end
        cdb = '{tag: 4'd1, val: 32'h0};
        tick();
        idle();
        checks++;
        if (issue_tag !== 4'd1 || sb.size() != 0) begin
            failures++;
            $display("FAIL ready_free got it=%0d pending=%0d required it=1 pending=0", issue_tag, sb.size());
        end
    endtask

    task automatic test_cdb_capture();
        do_reset();
        drive_issue(OP_SUB, 4'd7, NO_VAL, 32'hdead, 32'h11);
        tick();
        issue_valid = 1'b0;
        cdb = '{tag: 4'd1, val: 32'h99};
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        checks++;
        if (dispatch_valid !== 1'b0 || issue_tag !== 4'd2) begin
            failures++;
            $display("FAIL waiting_hold got dv=%0b it=%0d required dv=0 it=2", dispatch_valid, issue_tag);
        end
        cdb = '{tag: 4'd7, val: 32'h55};
        sb.push_back('{op: OP_SUB, a: 32'h55, b: 32'h11, tag: 4'd1});
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_a !== 32'h55) begin
            failures++;
            $display("FAIL cdb_capture got dv=%0b a=%0h required dv=1 a=55", dispatch_valid, dispatch_a);
        end
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        cdb = '{tag: 4'd1, val: '0};
        tick();
        idle();
        checks++;
        if (sb.size() != 0 || issue_tag !== 4'd1) begin
            failures++;
            $display("FAIL capture_drain got pending=%0d it=%0d required pending=0 it=1", sb.size(), issue_tag);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        drive_issue(OP_AND, NO_VAL, 4'd5, 32'd2, 32'hbad);
        cdb = '{tag: 4'd5, val: 32'd9};
        sb.push_back('{op: OP_AND, a: 32'd2, b: 32'd9, tag: 4'd1});
        tick();
        idle();
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_b !== 32'd9) begin
            failures++;
            $display("FAIL bypass got dv=%0b b=%0h required dv=1 b=9", dispatch_valid, dispatch_b);
        end
        fu_ready = 1'b1;
        tick();
        idle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bypass_drain got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_issue(OP_OR, NO_VAL, NO_VAL, val_t'(i + 10), val_t'(i + 20));
            checks++;
            if (issue_ready !== 1'b1 || issue_tag !== tag_t'(i + 1)) begin
                failures++;
                $display("FAIL fill_tag got ir=%0b it=%0d required ir=1 it=%0d", issue_ready, issue_tag, i + 1);
            end
            sb.push_back('{op: OP_OR, a: val_t'(i + 10), b: val_t'(i + 20), tag: tag_t'(i + 1)});
            tick();
        end
        drive_issue(OP_ADD, NO_VAL, NO_VAL, 32'hff, 32'hff);
        checks++;
        if (issue_ready !== 1'b0 || issue_tag !== NO_VAL) begin
            failures++;
            $display("FAIL full got ir=%0b it=%0d required ir=0 it=0", issue_ready, issue_tag);
        end
        tick();
        issue_valid = 1'b0;
        fu_ready = 1'b1;
        tick();
        tick();
        fu_ready = 1'b0;
        cdb = '{tag: 4'd2, val: '0};
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 4'd2 || dispatch_tag !== 4'd3) begin
            failures++;
            $display("FAIL free_entry1 got ir=%0b it=%0d dtag=%0d required ir=1 it=2 dtag=3",
                     issue_ready, issue_tag, dispatch_tag);
        end
        fu_ready = 1'b1;
        tick();
        tick();
        idle();
        checks++;
        if (dispatch_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL full_drain got dv=%0b pending=%0d required dv=0 pending=0", dispatch_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_issue(OP_ADD, NO_VAL, NO_VAL, 32'h100, 32'h200);
        sb.push_back('{op: OP_ADD, a: 32'h100, b: 32'h200, tag: 4'd1});
        tick();
        drive_issue(OP_SUB, NO_VAL, NO_VAL, 32'h300, 32'h400);
        sb.push_back('{op: OP_SUB, a: 32'h300, b: 32'h400, tag: 4'd2});
        tick();
        issue_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dispatch_valid !== 1'b1 || dispatch_tag !== 4'd1 || issue_tag !== 4'd3) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got dv=%0b dtag=%0d it=%0d required dv=1 dtag=1 it=3",
                         c, dispatch_valid, dispatch_tag, issue_tag);
            end
            tick();
        end
        fu_ready = 1'b1;
        tick();
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_tag !== 4'd2) begin
            failures++;
            $display("FAIL second_dispatch got dv=%0b dtag=%0d required dv=1 dtag=2", dispatch_valid, dispatch_tag);
        end
        tick();
        fu_ready = 1'b0;
        checks++;
        if (dispatch_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain got dv=%0b pending=%0d required dv=0 pending=0", dispatch_valid, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_issue(OP_ADD, NO_VAL, NO_VAL, 32'd1, 32'd2);
        sb.push_back('{op: OP_ADD, a: 32'd1, b: 32'd2, tag: 4'd1});
        tick();
        drive_issue(OP_OR, NO_VAL, NO_VAL, 32'd5, 32'd6);
        sb.push_back('{op: OP_OR, a: 32'd5, b: 32'd6, tag: 4'd2});
        tick();
        drive_issue(OP_AND, 4'd6, NO_VAL, 32'd0, 32'd7);
        tick();
        issue_valid = 1'b0;
        fu_ready = 1'b1;
        tick();
        tick();
        fu_ready = 1'b0;
        checks++;
        if (dispatch_valid !== 1'b0 || issue_tag !== 4'd4) begin
            failures++;
            $display("FAIL pre_reset got dv=%0b it=%0d required dv=0 it=4", dispatch_valid, issue_tag);
        end
        rst = 1'b1;
        issue_valid = 1'b1;
        fu_ready = 1'b1;
        cdb = '{tag: 4'd6, val: 32'd5};
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (dispatch_valid !== 1'b0 || issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            failures++;
            $display("FAIL mid_reset got dv=%0b ir=%0b it=%0d required dv=0 ir=1 it=1",
                     dispatch_valid, issue_ready, issue_tag);
        end
        cdb = '{tag: 4'd6, val: 32'd1};
        tick();
        idle();
        checks++;
        if (dispatch_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL discarded_entry got dv=%0b pending=%0d required dv=0 pending=0", dispatch_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_cdb_capture();
        test_bypass();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
